// File: rtl/s_mem_pkg.sv
// Shared constants and types for the RC4 S-array RAM arbiter.
package s_mem_pkg;

    localparam int S_AW     = 8;
    localparam int S_DW     = 8;
    localparam int REQ_INIT = 0;
    localparam int REQ_KSA  = 1;
    localparam int REQ_PRGA = 2;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWNED
    } arb_state_t;

endpackage

// File: rtl/s_mem_arbiter_if.sv
// Requester bundle plus RAM port of the S-array arbiter.
interface s_mem_arbiter_if
    import s_mem_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = S_AW,
    parameter int DW   = S_DW
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    acc;
    logic [NREQ-1:0]    wren;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic               mem_wren;
    logic [DW-1:0]      mem_q;
    logic [1:0]         owner;
    logic               busy;
    logic               err;

    modport master (
        output req, acc, wren, addr, wdata, mem_q,
        input  gnt, rvalid, rdata, mem_addr, mem_wdata,
        input  mem_wren, owner, busy, err
    );

    modport slave (
        input  req, acc, wren, addr, wdata, mem_q,
        output gnt, rvalid, rdata, mem_addr, mem_wdata,
        output mem_wren, owner, busy, err
    );

endinterface

// File: rtl/s_mem_arbiter_rr_pick.sv
// Round-robin selector: first set, non-excluded req after 'last', wrapping.
module rr_pick #(
    parameter int N = 3
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   last,
    input  logic [N-1:0] exclude,
    output logic         found,
    output logic [1:0]   sel
);

    logic [N-1:0] eff;
    int           idx;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        eff   = req & ~exclude;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!found && eff[idx]) begin
                found = 1'b1;
                sel   = 2'(idx);
            end
        end
    end

endmodule

// File: rtl/s_mem_arbiter.sv
// Round-robin owner arbiter and access mux for the shared S-array RAM.
module s_mem_arbiter
    import s_mem_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = S_AW,
    parameter int DW   = S_DW
) (
    input logic            CLOCK_50,
    input logic            reset_n,
    s_mem_arbiter_if.slave bus
);

    arb_state_t      state, state_n;
    logic [1:0]      owner_q, owner_n;
    logic [1:0]      last_q, last_n;
    logic            rd_pend;
    logic [1:0]      rd_who;
    logic            err_q;
    logic            busy_v;
    logic            legal;
    logic            viol;
    logic [NREQ-1:0] own_hot;
    logic [NREQ-1:0] gnt_v;
    logic            pick_found;
    logic [1:0]      pick_sel;
    logic [1:0]      pick_last;
    logic [NREQ-1:0] pick_excl;

    assign busy_v  = (state == ARB_OWNED);
    assign own_hot = NREQ'(1) << owner_q;
    assign gnt_v   = busy_v ? own_hot : '0;

    // One selector serves both idle arbitration and release handoff.
    assign pick_last = busy_v ? owner_q : last_q;
    assign pick_excl = busy_v ? own_hot : '0;

    rr_pick #(.N(NREQ)) u_pick (
        .req     (bus.req),
        .last    (pick_last),
        .exclude (pick_excl),
        .found   (pick_found),
        .sel     (pick_sel)
    );

    always_comb begin
        state_n = state;
        owner_n = owner_q;
        last_n  = last_q;
        unique case (state)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_n = ARB_OWNED;
                    owner_n = pick_sel;
                end
            end
            ARB_OWNED: begin
                if (!bus.req[owner_q]) begin
                    last_n = owner_q;
                    if (pick_found) begin
                        owner_n = pick_sel;
                    end else begin
                        state_n = ARB_IDLE;
                    end
                end
            end
        endcase
    end

    assign legal = busy_v & bus.acc[owner_q] & bus.req[owner_q];

    always_comb begin
        viol = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.acc[i] &&
                (!gnt_v[i] || !bus.req[i] || $isunknown(bus.wren[i]))) begin
                viol = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state   <= ARB_IDLE;
            owner_q <= '0;
            last_q  <= 2'(NREQ - 1);
            rd_pend <= 1'b0;
            rd_who  <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            owner_q <= owner_n;
            last_q  <= last_n;
            rd_pend <= legal & ~bus.wren[owner_q];
            rd_who  <= owner_q;
            err_q   <= err_q | viol;
        end
    end

    assign bus.gnt       = gnt_v;
    assign bus.busy      = busy_v;
    assign bus.owner     = owner_q;
    assign bus.err       = err_q;
    assign bus.rvalid    = rd_pend ? (NREQ'(1) << rd_who) : '0;
    assign bus.rdata     = bus.mem_q;
    assign bus.mem_addr  = busy_v ? bus.addr[owner_q*AW +: AW] : '0;
    assign bus.mem_wdata = busy_v ? bus.wdata[owner_q*DW +: DW] : '0;
    assign bus.mem_wren  = legal & bus.wren[owner_q];

endmodule

// File: tb/tb_s_mem_arbiter.sv
// Vector-table and scoreboard bench for s_mem_arbiter with a RAM model.
module tb_s_mem_arbiter;

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic [2:0] acc;
        logic [2:0] wren;
        logic [7:0] a;
        logic [7:0] d;
        logic [2:0] gnt;
        logic [1:0] own;
        logic       busy;
        logic       mwren;
        logic       rd;
        logic       err;
    } vec_t;

    typedef struct {
        logic [2:0] who;
        logic [7:0] data;
        int         due;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset_n;
    int     n_chk = 0;
    int     n_bad = 0;
    int     cyc = 0;
    vec_t   tv[$];
    exp_t   sb[$];
    exp_t   mon_e;
    logic [7:0] ram [256];
    logic [7:0] sh [256];

    s_mem_arbiter_if #(.NREQ(3), .AW(8), .DW(8)) bus ();

    s_mem_arbiter #(.NREQ(3), .AW(8), .DW(8)) dut (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered inputs; write data shows on q.
    always @(posedge clk) begin
        if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_q <= bus.mem_wren ? bus.mem_wdata : ram[bus.mem_addr];
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, want, cyc);
        end
    endtask

    function automatic vec_t mk(
        logic rst, logic [2:0] req, logic [2:0] acc, logic [2:0] wren,
        logic [7:0] a, logic [7:0] d, logic [2:0] gnt, logic [1:0] own,
        logic busy, logic mwren, logic rd, logic err);
        vec_t v;
        v.rst = rst;   v.req = req;     v.acc = acc; v.wren = wren;
        v.a = a;       v.d = d;         v.gnt = gnt; v.own = own;
        v.busy = busy; v.mwren = mwren; v.rd = rd;   v.err = err;
        return v;
    endfunction

    always @(posedge clk) begin
        cyc++;
        #2;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            mon_e = sb.pop_front();
            chk("rvalid_missing", 32'(bus.rvalid), 32'(mon_e.who));
        end
        if (bus.rvalid != 3'b000) begin
            if (sb.size() == 0) begin
                chk("rvalid_spurious", 32'(bus.rvalid), 32'h0);
            end else begin
                mon_e = sb.pop_front();
                chk("rvalid_who", 32'(bus.rvalid), 32'(mon_e.who));
                chk("rvalid_cycle", 32'(cyc), 32'(mon_e.due));
                chk("rdata", 32'(bus.rdata), 32'(mon_e.data));
            end
        end
    end

    task automatic apply(vec_t v, int row);
        logic [23:0] av;
        logic [23:0] dv;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            av[i*8 +: 8] = (v.busy && i == int'(v.own)) ? v.a : v.a ^ 8'hFF;
            dv[i*8 +: 8] = (v.busy && i == int'(v.own)) ? v.d : v.d ^ 8'hFF;
        end
        reset_n   = v.rst;
        bus.req   = v.req;
        bus.acc   = v.acc;
        bus.wren  = v.wren;
        bus.addr  = av;
        bus.wdata = dv;
        if (v.rd) sb.push_back('{3'b001 << v.own, sh[v.a], cyc + 1});
        if (v.mwren) sh[v.a] = v.d;
        #1;
        chk($sformatf("gnt[%0d]", row), 32'(bus.gnt), 32'(v.gnt));
        chk($sformatf("busy[%0d]", row), 32'(bus.busy), 32'(v.busy));
        if (v.busy)
            chk($sformatf("owner[%0d]", row), 32'(bus.owner), 32'(v.own));
        chk($sformatf("mem_wren[%0d]", row), 32'(bus.mem_wren), 32'(v.mwren));
        chk($sformatf("err[%0d]", row), 32'(bus.err), 32'(v.err));
        chk($sformatf("mem_addr[%0d]", row), 32'(bus.mem_addr),
            32'(v.busy ? v.a : 8'h00));
        chk($sformatf("mem_wdata[%0d]", row), 32'(bus.mem_wdata),
            32'(v.busy ? v.d : 8'h00));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i] = 8'h00;
            sh[i]  = 8'h00;
        end
        bus.mem_q = 8'h00;
        reset_n   = 1'b0;
        bus.req   = '0;
        bus.acc   = '0;
        bus.wren  = '0;
        bus.addr  = '0;
        bus.wdata = '0;

        //         rst req    acc    wren   a      d      gnt    o  b  w  r  e
        tv.push_back(mk(0, 3'b111, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 3'b111, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 3'b111, 3'b000, 3'b000, 8'h00, 8'h00, 3'b001, 0, 1, 0, 0, 0));
        tv.push_back(mk(1, 3'b111, 3'b001, 3'b001, 8'h20, 8'h11, 3'b001, 0, 1, 1, 0, 0));
        tv.push_back(mk(1, 3'b111, 3'b001, 3'b000, 8'h20, 8'h00, 3'b001, 0, 1, 0, 1, 0));
        tv.push_back(mk(1, 3'b110, 3'b000, 3'b000, 8'h00, 8'h00, 3'b001, 0, 1, 0, 0, 0));
        tv.push_back(mk(1, 3'b110, 3'b010, 3'b010, 8'h10, 8'hA5, 3'b010, 1, 1, 1, 0, 0));
        tv.push_back(mk(1, 3'b110, 3'b010, 3'b000, 8'h10, 8'h00, 3'b010, 1, 1, 0, 1, 0));
        tv.push_back(mk(1, 3'b101, 3'b000, 3'b000, 8'h00, 8'h00, 3'b010, 1, 1, 0, 0, 0));
        tv.push_back(mk(1, 3'b001, 3'b000, 3'b000, 8'h00, 8'h00, 3'b100, 2, 1, 0, 0, 0));
        tv.push_back(mk(1, 3'b001, 3'b100, 3'b100, 8'h30, 8'hFF, 3'b001, 0, 1, 0, 0, 0));
        tv.push_back(mk(1, 3'b001, 3'b000, 3'b000, 8'h00, 8'h00, 3'b001, 0, 1, 0, 0, 1));
        tv.push_back(mk(1, 3'b001, 3'b001, 3'b000, 8'h10, 8'h00, 3'b001, 0, 1, 0, 1, 1));
        tv.push_back(mk(1, 3'b001, 3'b001, 3'b000, 8'h30, 8'h00, 3'b001, 0, 1, 0, 1, 1));
        tv.push_back(mk(1, 3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 3'b001, 0, 1, 0, 0, 1));
        tv.push_back(mk(1, 3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 0, 0, 0, 0, 1));
        tv.push_back(mk(1, 3'b010, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 0, 0, 0, 0, 1));
        tv.push_back(mk(1, 3'b010, 3'b000, 3'b000, 8'h00, 8'h00, 3'b010, 1, 1, 0, 0, 1));
        tv.push_back(mk(0, 3'b010, 3'b010, 3'b000, 8'h10, 8'h00, 3'b010, 1, 1, 0, 0, 1));
        tv.push_back(mk(1, 3'b111, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 3'b100, 3'b000, 3'b000, 8'h00, 8'h00, 3'b001, 0, 1, 0, 0, 0));
        tv.push_back(mk(1, 3'b100, 3'b100, 3'b100, 8'h44, 8'h5A, 3'b100, 2, 1, 1, 0, 0));
        tv.push_back(mk(1, 3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 3'b100, 2, 1, 0, 0, 0));
        tv.push_back(mk(1, 3'b100, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 3'b100, 3'b100, 3'b000, 8'h44, 8'h00, 3'b100, 2, 1, 0, 1, 0));
        tv.push_back(mk(1, 3'b100, 3'b100, 3'b000, 8'h10, 8'h00, 3'b100, 2, 1, 0, 1, 0));
        tv.push_back(mk(1, 3'b000, 3'b100, 3'b000, 8'h44, 8'h00, 3'b100, 2, 1, 0, 0, 0));
        tv.push_back(mk(1, 3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 0, 0, 0, 0, 1));

        repeat (2) @(negedge clk);
        for (int r = 0; r < tv.size(); r++) apply(tv[r], r);

        // err must stay set until a reset clears it.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.req = '0;
            bus.acc = '0;
            #1;
            chk("err_sticky", 32'(bus.err), 32'h1);
        end
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("err_cleared", 32'(bus.err), 32'h0);
        chk("busy_cleared", 32'(bus.busy), 32'h0);
        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
